// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// rtl/pipeline_hazard_ctrl_hazard_detect.sv - combinational decode-operand vs ex/mem destination compare
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic       ex_rd_we,
  input  logic [4:0] ex_rd,
  input  logic       mem_valid,
  input  logic       mem_rd_we,
  input  logic [4:0] mem_rd,
  output logic       hazard
);

  logic ex_wr;
  logic mem_wr;
  logic rs1_hit;
  logic rs2_hit;

  // A source conflicts when any in-flight writer targets it; r0 is hardwired and never conflicts.
  always_comb begin
    ex_wr   = ex_valid && ex_rd_we;
    mem_wr  = mem_valid && mem_rd_we;
    rs1_hit = id_uses_rs1 && (id_rs1 != REG_ZERO) &&
              ((ex_wr && (ex_rd == id_rs1)) || (mem_wr && (mem_rd == id_rs1)));
    rs2_hit = id_uses_rs2 && (id_rs2 != REG_ZERO) &&
              ((ex_wr && (ex_rd == id_rs2)) || (mem_wr && (mem_rd == id_rs2)));
    hazard  = id_valid && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/redirect sequencing; optional counters under PIPE_CTRL_PERF_EN
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_is_jump,
  input  logic [XLEN-1:0] id_jump_target,
  input  logic            ex_valid,
  input  logic            ex_rd_we,
  input  logic [4:0]      ex_rd,
  input  logic            mem_valid,
  input  logic            mem_rd_we,
  input  logic [4:0]      mem_rd,
  input  logic            br_resolve,
  input  logic            br_mispredict,
  input  logic [XLEN-1:0] br_correct_pc,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flush_cycles,
  output logic [31:0]     perf_mispredicts,
`endif
  output logic            pc_stall,
  output logic            id_stall,
  output logic            id_flush,
  output logic            ex_bubble,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  ctrl_state_t      state;
  ctrl_state_t      next_state;
  logic [CNT_W-1:0] flush_cnt;
  logic             hazard;
  logic             mispredict;
  logic             jump_take;

  hazard_detect u_hazard_detect (
    .id_valid    (id_valid),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_valid    (ex_valid),
    .ex_rd_we    (ex_rd_we),
    .ex_rd       (ex_rd),
    .mem_valid   (mem_valid),
    .mem_rd_we   (mem_rd_we),
    .mem_rd      (mem_rd),
    .hazard      (hazard)
  );

  // Event decode: a mispredict is honoured in any state, a jump only while running.
  always_comb begin
    mispredict = br_resolve && br_mispredict;
    jump_take  = (state == RUN) && id_valid && id_is_jump;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next state and control outputs; mispredict outranks jump, jump outranks hazard, and all are zero in reset.
  always_comb begin
    next_state = state;
    pc_stall   = 1'b0;
    id_stall   = 1'b0;
    id_flush   = 1'b0;
    ex_bubble  = 1'b0;
    if (rst_n) begin
      if (state == FLUSH) begin
        id_flush  = 1'b1;
        ex_bubble = 1'b1;
        if (flush_cnt == CNT_W'(1)) begin
          next_state = RUN;
        end
      end else if (!mispredict) begin
        if (jump_take) begin
          id_flush = 1'b1;
        end else if (hazard) begin
          pc_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_bubble = 1'b1;
        end
      end
      if (mispredict) begin
        next_state = FLUSH;
      end
    end
  end

  // Flush counter: reloaded by every mispredict, counts down while squashing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (mispredict) begin
      flush_cnt <= CNT_W'(FLUSH_CYCLES);
    end else if (state == FLUSH) begin
      flush_cnt <= flush_cnt - CNT_W'(1);
    end
  end

  // Redirect pulse and target; the target holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (mispredict) begin
      redirect_valid <= 1'b1;
      redirect_pc    <= br_correct_pc;
    end else if (jump_take) begin
      redirect_valid <= 1'b1;
      redirect_pc    <= id_jump_target;
    end else begin
      redirect_valid <= 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Saturating event counters: hazard-stall cycles, FLUSH cycles, mispredict events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flush_cycles <= '0;
      perf_mispredicts  <= '0;
    end else begin
      if (pc_stall && (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if ((state == FLUSH) && (perf_flush_cycles != '1)) begin
        perf_flush_cycles <= perf_flush_cycles + 32'd1;
      end
      if (mispredict && (perf_mispredicts != '1)) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl with a behavioural model
module tb_pipeline_hazard_ctrl;

  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid, id_uses_rs1, id_uses_rs2, id_is_jump;
  logic [4:0]      id_rs1, id_rs2, ex_rd, mem_rd;
  logic [XLEN-1:0] id_jump_target, br_correct_pc;
  logic            ex_valid, ex_rd_we, mem_valid, mem_rd_we;
  logic            br_resolve, br_mispredict;
  logic            pc_stall, id_stall, id_flush, ex_bubble, redirect_valid;
  logic [XLEN-1:0] redirect_pc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]     perf_stall_cycles, perf_flush_cycles, perf_mispredicts;
  int unsigned     m_ps, m_fc, m_mp;
`endif

  int              ncmp = 0;
  int              nfail = 0;

  // Model: flush cycles still owed (0 = running), pending redirect pulse and held target.
  int              m_left;
  logic            m_rv;
  logic [XLEN-1:0] m_rpc;
  logic            e_stall, e_flush, e_bubble;

  pipeline_hazard_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_is_jump     (id_is_jump),
    .id_jump_target (id_jump_target),
    .ex_valid       (ex_valid),
    .ex_rd_we       (ex_rd_we),
    .ex_rd          (ex_rd),
    .mem_valid      (mem_valid),
    .mem_rd_we      (mem_rd_we),
    .mem_rd         (mem_rd),
    .br_resolve     (br_resolve),
    .br_mispredict  (br_mispredict),
    .br_correct_pc  (br_correct_pc),
`ifdef PIPE_CTRL_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_cycles (perf_flush_cycles),
    .perf_mispredicts  (perf_mispredicts),
`endif
    .pc_stall       (pc_stall),
    .id_stall       (id_stall),
    .id_flush       (id_flush),
    .ex_bubble      (ex_bubble),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit reads_busy(input logic used, input logic [4:0] r);
    bit busy;
    busy = (ex_valid && ex_rd_we && ex_rd == r) || (mem_valid && mem_rd_we && mem_rd == r);
    return used && (r != 5'd0) && busy;
  endfunction

  task automatic idle();
    id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_is_jump = 0;
    id_rs1 = 0; id_rs2 = 0; id_jump_target = 0;
    ex_valid = 0; ex_rd_we = 0; ex_rd = 0;
    mem_valid = 0; mem_rd_we = 0; mem_rd = 0;
    br_resolve = 0; br_mispredict = 0; br_correct_pc = 0;
  endtask

  task automatic model_reset();
    m_left = 0; m_rv = 0; m_rpc = '0;
`ifdef PIPE_CTRL_PERF_EN
    m_ps = 0; m_fc = 0; m_mp = 0;
`endif
  endtask

  // Check one cycle against the model, then advance model and DUT across the clock edge.
  task automatic step();
    bit mp, jmp, hz;
    #3;
    mp  = br_resolve && br_mispredict;
    jmp = id_valid && id_is_jump;
    hz  = id_valid && (reads_busy(id_uses_rs1, id_rs1) || reads_busy(id_uses_rs2, id_rs2));
    e_stall = 0; e_flush = 0; e_bubble = 0;
    if (m_left > 0) begin
      e_flush = 1; e_bubble = 1;
    end else if (!mp) begin
      if (jmp) e_flush = 1;
      else if (hz) begin e_stall = 1; e_bubble = 1; end
    end
    chk("pc_stall", pc_stall, e_stall);
    chk("id_stall", id_stall, e_stall);
    chk("id_flush", id_flush, e_flush);
    chk("ex_bubble", ex_bubble, e_bubble);
    chk("redirect_valid", redirect_valid, m_rv);
    chk("redirect_pc", redirect_pc, m_rpc);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall", perf_stall_cycles, m_ps);
    chk("perf_flush", perf_flush_cycles, m_fc);
    chk("perf_mp", perf_mispredicts, m_mp);
    m_ps += e_stall;
    m_fc += (m_left > 0);
    m_mp += mp;
`endif
    if (mp) begin
      m_rv = 1; m_rpc = br_correct_pc; m_left = FC;
    end else if (m_left == 0 && jmp) begin
      m_rv = 1; m_rpc = id_jump_target;
    end else begin
      m_rv = 0;
      if (m_left > 0) m_left--;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    #2;
    chk("rst_pc_stall", pc_stall, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    @(posedge clk); #1;
    rst_n = 1;
    step();

    // ADD r3 in ex, then in mem, decode reads r3: two stall cycles then clear.
    ex_valid = 1; ex_rd_we = 1; ex_rd = 3;
    id_valid = 1; id_uses_rs1 = 1; id_uses_rs2 = 1; id_rs1 = 3; id_rs2 = 7;
    #1 chk("hz_ex_stall", pc_stall, 1);
    step();
    ex_valid = 0; mem_valid = 1; mem_rd_we = 1; mem_rd = 3;
    #1 chk("hz_mem_stall", id_stall, 1);
    step();
    mem_valid = 0;
    #1 chk("hz_clear", pc_stall, 0);
    step();

    // r0 never hazards.
    ex_valid = 1; ex_rd_we = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    #1 chk("r0_no_stall", pc_stall, 0);
    step();
    idle();
    step();

    // Mispredict to 0x40 at N, second mispredict to 0x80 at N+1.
    br_resolve = 1; br_mispredict = 1; br_correct_pc = 32'h40;
    step();
    br_correct_pc = 32'h80;
    #1 chk("mp_rv_n1", redirect_valid, 1);
    chk("mp_pc_n1", redirect_pc, 32'h40);
    chk("mp_flush_n1", id_flush, 1);
    step();
    idle();
    #1 chk("mp2_pc_n2", redirect_pc, 32'h80);
    step();
    #1 chk("mp2_flush_n3", id_flush, 1);
    step();
    #1 chk("mp2_run_n4", id_flush, 0);
    step();

    // JAL to 0x100: flush now, redirect next cycle.
    id_valid = 1; id_is_jump = 1; id_jump_target = 32'h100;
    #1 chk("jal_flush", id_flush, 1);
    step();
    idle();
    #1 chk("jal_rv", redirect_valid, 1);
    chk("jal_pc", redirect_pc, 32'h100);
    step();
    step();

    // JAL with simultaneous mispredict to 0x20: mispredict wins.
    id_valid = 1; id_is_jump = 1; id_jump_target = 32'h100;
    br_resolve = 1; br_mispredict = 1; br_correct_pc = 32'h20;
    step();
    idle();
    #1 chk("jal_mp_pc", redirect_pc, 32'h20);
    step();

    // Reset mid-flush (N+2 of the mispredict above is already flushing): everything zero at once.
    rst_n = 0;
    #1;
    chk("rst_mid_flush", id_flush, 0);
    chk("rst_mid_bubble", ex_bubble, 0);
    chk("rst_mid_rv", redirect_valid, 0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rst_perf_flush", perf_flush_cycles, 0);
    chk("rst_perf_mp", perf_mispredicts, 0);
`endif
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    step();

    // Randomized traffic with a narrow register range so conflicts are frequent.
    for (int i = 0; i < 400; i++) begin
      id_valid       = ($urandom_range(0, 3) != 0);
      id_uses_rs1    = $urandom_range(0, 1);
      id_uses_rs2    = $urandom_range(0, 1);
      id_rs1         = 5'($urandom_range(0, 3));
      id_rs2         = 5'($urandom_range(0, 3));
      id_is_jump     = ($urandom_range(0, 7) == 0);
      id_jump_target = $urandom;
      ex_valid       = $urandom_range(0, 1);
      ex_rd_we       = $urandom_range(0, 1);
      ex_rd          = 5'($urandom_range(0, 3));
      mem_valid      = $urandom_range(0, 1);
      mem_rd_we      = $urandom_range(0, 1);
      mem_rd         = 5'($urandom_range(0, 3));
      br_resolve     = ($urandom_range(0, 3) == 0);
      br_mispredict  = ($urandom_range(0, 2) == 0);
      br_correct_pc  = $urandom;
      step();
    end

    idle();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the five-stage branch-prediction core. It sits beside the decode stage and watches decoded operands against in-flight destinations in execute and memory. It issues stall and bubble control for data hazards, and it squashes and redirects fetch on decode-stage jumps and execute-stage branch mispredicts. It is the only source of stall, flush and redirect in the pipeline.

## Interface
Parameters:
- XLEN, 32, width of PC and redirect targets
- FLUSH_CYCLES, 2, cycles of decode squash after a mispredict redirect (≥1)

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  decode holds a real instruction (low for NOP/invalid)
- id_uses_rs1, id_uses_rs2  in  1 each  decoded instruction reads rs1/rs2 (ADD: both; BNE: both; JAL: none)
- id_rs1, id_rs2  in  5 each  decoded source registers
- id_is_jump  in  1  decode holds a jump
- id_jump_target  in  XLEN  resolved jump target
- ex_valid, ex_rd_we  in  1 each  execute-stage instruction valid / writes rd
- ex_rd  in  5  execute-stage destination
- mem_valid, mem_rd_we  in  1 each  memory-stage equivalents
- mem_rd  in  5  memory-stage destination
- br_resolve  in  1  execute resolves a branch this cycle
- br_mispredict  in  1  qualified by br_resolve; prediction was wrong
- br_correct_pc  in  XLEN  correct next PC for the mispredicted branch
- pc_stall  out  1  hold PC and fetch register
- id_stall  out  1  hold decode register
- id_flush  out  1  convert decode-register contents to NOP
- ex_bubble  out  1  inject NOP into execute on next edge
- redirect_valid  out  1  one-cycle pulse; fetch loads redirect_pc
- redirect_pc  out  XLEN  redirect target

## Operation
- FSM states: RUN, FLUSH. Reset → RUN, flush counter 0, redirect_valid=0, redirect_pc=0; all combinational outputs evaluate to 0 in reset.
- Hazard (RUN only): id_valid && ((id_uses_rs1 && id_rs1≠0 && match) || same for rs2), where match = (ex_valid && ex_rd_we && ex_rd==rs) || (mem_valid && mem_rd_we && mem_rd==rs). No forwarding; register file is write-before-read, so writeback is not checked. Register 0 never hazards.
- Hazard response: pc_stall=id_stall=ex_bubble=1, combinational, same cycle. Stays asserted until the producer leaves memory.
- Priority within a cycle: mispredict > jump > hazard.
- Mispredict (br_resolve && br_mispredict, any state): next edge registers redirect_pc=br_correct_pc and redirect_valid=1, enters FLUSH, and loads counter=FLUSH_CYCLES. A mispredict while in FLUSH restarts the counter and re-redirects to the new PC.
- FLUSH: id_flush=ex_bubble=1 every cycle, and the counter decrements. When the counter reaches 1 → RUN. Jumps and hazards are ignored in FLUSH; decode contents are dead.
- Jump (RUN, id_valid && id_is_jump, no mispredict): next edge registers redirect_valid=1 and redirect_pc=id_jump_target. In the same cycle id_flush=1 squashes the wrong-path fetch. Stays in RUN. A jump that coincides with a hazard is not possible (JAL reads no sources). If it occurs, the jump wins.
- redirect_valid deasserts the cycle after any pulse unless a new event occurs.

## Timing
- Hazard stall: zero-cycle latency, combinational from inputs.
- Mispredict at cycle N: redirect_valid at N+1; id_flush/ex_bubble high N+1..N+FLUSH_CYCLES; RUN at N+FLUSH_CYCLES+1.
- Jump at cycle N: id_flush at N, redirect_valid at N+1.
- rst_n low mid-FLUSH: immediate return to RUN, counter 0, redirect_valid=0.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs perf_stall_cycles, perf_flush_cycles, perf_mispredicts (32 bits each). These count hazard-stall cycles, FLUSH cycles, and mispredict events. They saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package pipe_ctrl_pkg: state enum (RUN, FLUSH), REG_ZERO constant, XLEN default.
- One sub-module, hazard_detect: purely combinational operand-vs-destination compare producing hazard. The FSM, counter and redirect registers live in the top.

## Test plan
- ADD r3 in ex, decode ADD reading rs1=3 → pc_stall=id_stall=ex_bubble=1 for 2 cycles (ex then mem), then 0.
- Decode reads r0 while ex writes r0 → no stall.
- br_resolve=br_mispredict=1, br_correct_pc=0x40 at cycle N → redirect_valid=1, redirect_pc=0x40 at N+1; id_flush high N+1..N+2; RUN at N+3.
- Second mispredict (pc 0x80) at N+1 → redirect to 0x80 at N+2, flush extends through N+3.
- JAL target 0x100 in decode → id_flush same cycle, redirect_valid/0x100 next cycle; a simultaneous mispredict to 0x20 wins instead.
- rst_n asserted at N+1 of a flush → all outputs 0 immediately; with PIPE_CTRL_PERF_EN, counters read 0.
